// File: rtl/mem_copy_pkg.sv
// Shared types and helpers for the mem_copy_dma block mover.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic MODE_COPY  = 1'b0;
  localparam logic MODE_CLEAR = 1'b1;

  function automatic int unsigned lanes_of(input int unsigned data_w,
                                           input int unsigned elem_w);
    return data_w / elem_w;
  endfunction

  function automatic int unsigned addr_w_of(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_copy_dly.sv
// RD_LAT-stage shift register carrying {valid, index} from read issue to write.
module mem_copy_dly
  import mem_copy_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned IDX_W  = 7
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_v,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_v,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W:0] stage_q [RD_LAT];
  logic [IDX_W:0] stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = {i_v, i_idx};
    for (int unsigned s = 1; s < RD_LAT; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign {o_v, o_idx} = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_copy_dma.sv
// BRAM-to-BRAM block mover with COPY/CLEAR modes, abort and range checking.
// Optional MEM_COPY_RELU_EN: COPY clamps negative signed lanes to zero.
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned I_F_BW = 8,
  parameter  int unsigned DEPTH  = 100,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned ADDR_W = addr_w_of(DEPTH)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              i_run,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_abort,
  input  logic              i_clr_err,
  output logic              o_idle,
  output logic              o_run,
  output logic              o_en_err,
  output logic              o_ot_done,
  output logic [ADDR_W-1:0] b_o_src_addr,
  output logic              b_o_src_ce,
  input  logic [DATA_W-1:0] b_i_src_q,
  output logic [ADDR_W-1:0] b_o_dst_addr,
  output logic              b_o_dst_ce,
  output logic              b_o_dst_we,
  output logic [DATA_W-1:0] b_o_dst_d
);

  localparam int unsigned LANES = lanes_of(DATA_W, I_F_BW);
  localparam int unsigned RW    = ADDR_W + 2;
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [RW-1:0]    DEPTH_W    = RW'(DEPTH);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              src_ce_q, src_ce_d;
  logic              iss_v_q, iss_v_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [RW-1:0]     src_end, dst_end;
  logic              start_ok, last_issue, bad_run, abort_go;
  logic              wr_v, wr_go;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] copy_data;

  always_comb begin
    src_end    = RW'(i_src_base) + RW'(i_len);
    dst_end    = RW'(i_dst_base) + RW'(i_len);
    start_ok   = (i_len != '0) && (src_end <= DEPTH_W) && (dst_end <= DEPTH_W);
    last_issue = ((RW'(idx_q) + RW'(1)) == RW'(len_q));
    abort_go   = i_abort && (state_q != ST_IDLE);
    bad_run    = i_run && ((state_q != ST_IDLE) || !start_ok);

    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    dst_base_d = dst_base_q;
    src_addr_d = src_addr_q;
    src_ce_d   = src_ce_q;
    iss_v_d    = iss_v_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    done_d     = 1'b0;

    // a new error outranks a simultaneous clear
    err_d = err_q;
    if (i_clr_err) err_d = 1'b0;
    if (bad_run)   err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (i_run && start_ok) begin
          state_d    = ST_RUN;
          mode_d     = i_mode;
          len_d      = i_len;
          dst_base_d = i_dst_base;
          src_addr_d = i_src_base;
          src_ce_d   = (i_mode == MODE_COPY);
          iss_v_d    = 1'b1;
          idx_d      = '0;
        end
      end
      ST_RUN: begin
        if (last_issue) begin
          state_d  = ST_DRAIN;
          src_ce_d = 1'b0;
          iss_v_d  = 1'b0;
          drain_d  = '0;
        end else begin
          idx_d      = idx_q + ADDR_W'(1);
          src_addr_d = src_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_go) begin
      state_d  = ST_IDLE;
      src_ce_d = 1'b0;
      iss_v_d  = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_COPY;
      len_q      <= '0;
      dst_base_q <= '0;
      src_addr_q <= '0;
      src_ce_q   <= 1'b0;
      iss_v_q    <= 1'b0;
      idx_q      <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      dst_base_q <= dst_base_d;
      src_addr_q <= src_addr_d;
      src_ce_q   <= src_ce_d;
      iss_v_q    <= iss_v_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  mem_copy_dly #(
    .RD_LAT (RD_LAT),
    .IDX_W  (ADDR_W)
  ) u_dly (
    .clk   (clk),
    .i_clr (areset | abort_go),
    .i_v   (iss_v_q),
    .i_idx (idx_q),
    .o_v   (wr_v),
    .o_idx (wr_idx)
  );

  always_comb begin
    copy_data = b_i_src_q;
    for (int unsigned l = 0; l < LANES; l++) begin
`ifdef MEM_COPY_RELU_EN
      if (b_i_src_q[l*I_F_BW + I_F_BW - 1]) copy_data[l*I_F_BW +: I_F_BW] = '0;
`else
      copy_data[l*I_F_BW +: I_F_BW] = b_i_src_q[l*I_F_BW +: I_F_BW];
`endif
    end
  end

  // the write stage is combinational off the delay line, so reset must mask it
  assign wr_go        = wr_v && !areset;
  assign b_o_dst_we   = wr_go;
  assign b_o_dst_ce   = wr_go;
  assign b_o_dst_addr = dst_base_q + wr_idx;
  assign b_o_dst_d    = (!wr_go || mode_q == MODE_CLEAR) ? '0 : copy_data;

  assign b_o_src_addr = src_addr_q;
  assign b_o_src_ce   = src_ce_q;
  assign o_idle       = (state_q == ST_IDLE);
  assign o_run        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_en_err     = err_q;
  assign o_ot_done    = done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: instances with RD_LAT 1 and 3, BRAM models.
`timescale 1ns/1ps
module tb_mem_copy_dma;

  localparam int DW    = 32;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic fill = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] src_mem [DEPTH];
  logic [DW-1:0] dst_mem [2][DEPTH];
  logic [DW-1:0] pipe    [2][4];

  logic          run_i [2], mode_i [2], abort_i [2], clr_i [2];
  logic [AW-1:0] srcb_i [2], dstb_i [2];
  logic [AW:0]   len_i [2];
  logic          idle_o [2], run_o [2], err_o [2], done_o [2];
  logic          src_ce_o [2], dst_ce_o [2], dst_we_o [2];
  logic [AW-1:0] src_addr_o [2], dst_addr_o [2];
  logic [DW-1:0] src_q_i [2], dst_d_o [2];

  wr_t exp_wr   [2][256];
  int  exp_done [2][16];
  int  wr_h [2], wr_tl [2], dn_h [2], dn_tl [2];
  int  we_cnt [2], ce_cnt [2];
  wr_t mon_e;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_copy_dma #(
      .DATA_W (32),
      .I_F_BW (8),
      .DEPTH  (100),
      .RD_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk          (clk),
      .areset       (areset),
      .i_run        (run_i[g]),
      .i_mode       (mode_i[g]),
      .i_src_base   (srcb_i[g]),
      .i_dst_base   (dstb_i[g]),
      .i_len        (len_i[g]),
      .i_abort      (abort_i[g]),
      .i_clr_err    (clr_i[g]),
      .o_idle       (idle_o[g]),
      .o_run        (run_o[g]),
      .o_en_err     (err_o[g]),
      .o_ot_done    (done_o[g]),
      .b_o_src_addr (src_addr_o[g]),
      .b_o_src_ce   (src_ce_o[g]),
      .b_i_src_q    (src_q_i[g]),
      .b_o_dst_addr (dst_addr_o[g]),
      .b_o_dst_ce   (dst_ce_o[g]),
      .b_o_dst_we   (dst_we_o[g]),
      .b_o_dst_d    (dst_d_o[g])
    );
  end

  // BRAM models: source read pipeline of depth RD_LAT, destination write port
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= src_ce_o[g] ? src_mem[src_addr_o[g]] : 32'hDEADBEEF;
      for (int s = 1; s < 4; s++) pipe[g][s] <= pipe[g][s-1];
      if (fill) begin
        for (int i = 0; i < DEPTH; i++) dst_mem[g][i] <= 32'hA5A5A5A5;
      end else if (dst_we_o[g] && dst_ce_o[g] && int'(dst_addr_o[g]) < DEPTH) begin
        dst_mem[g][dst_addr_o[g]] <= dst_d_o[g];
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) src_q_i[g] = pipe[g][lat_of(g)-1];
  end

  task automatic check(input int g, input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [lat%0d] cyc=%0d actual=%0h required=%0h", nm, lat_of(g), cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic mode, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    if (mode) return '0;
    r = w;
`ifdef MEM_COPY_RELU_EN
    for (int l = 0; l < 4; l++) if (w[8*l+7]) r[8*l +: 8] = 8'h00;
`endif
    return r;
  endfunction

  // monitor: pops the scoreboard whenever a DUT presents a write or a done
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (src_ce_o[g]) ce_cnt[g]++;
      if (dst_we_o[g]) begin
        we_cnt[g]++;
        check(g, "wr_ce", {63'b0, dst_ce_o[g]}, 64'd1);
        check(g, "wr_expected", {63'b0, wr_h[g] != wr_tl[g]}, 64'd1);
        if (wr_h[g] != wr_tl[g]) begin
          mon_e = exp_wr[g][wr_h[g] % 256];
          wr_h[g]++;
          check(g, "write", {25'b0, dst_addr_o[g], dst_d_o[g]}, {25'b0, mon_e.a, mon_e.d});
        end
      end
      if (done_o[g]) begin
        check(g, "done_expected", {63'b0, dn_h[g] != dn_tl[g]}, 64'd1);
        check(g, "idle_at_done", {63'b0, idle_o[g]}, 64'd1);
        if (dn_h[g] != dn_tl[g]) begin
          check(g, "done_cycle", 64'(cyc), 64'(exp_done[g][dn_h[g] % 16]));
          dn_h[g]++;
        end
      end
    end
  end

  task automatic launch(input int g, input logic mode, input int src, input int dst,
                        input int len, input int nwr, input bit want_done, output int start);
    start = cyc;
    for (int k = 0; k < nwr; k++) begin
      exp_wr[g][wr_tl[g] % 256] = '{a: AW'(dst + k), d: exp_data(mode, src_mem[src + k])};
      wr_tl[g]++;
    end
    if (want_done) begin
      exp_done[g][dn_tl[g] % 16] = start + len + lat_of(g) + 1;
      dn_tl[g]++;
    end
    run_i[g]  = 1'b1;
    mode_i[g] = mode;
    srcb_i[g] = AW'(src);
    dstb_i[g] = AW'(dst);
    len_i[g]  = (AW+1)'(len);
    @(negedge clk);
    run_i[g] = 1'b0;
  endtask

  task automatic finish_chk(input int g, input int we0, input int ce0,
                            input int exp_we, input int exp_ce);
    check(g, "we_count", 64'(we_cnt[g] - we0), 64'(exp_we));
    check(g, "ce_count", 64'(ce_cnt[g] - ce0), 64'(exp_ce));
    check(g, "wr_pending", 64'(wr_tl[g] - wr_h[g]), 64'd0);
    check(g, "done_pending", 64'(dn_tl[g] - dn_h[g]), 64'd0);
    check(g, "idle", {63'b0, idle_o[g]}, 64'd1);
  endtask

  task automatic illegal(input int g, input int src, input int dst, input int len,
                         input logic clr);
    int we0, ce0;
    we0 = we_cnt[g];
    ce0 = ce_cnt[g];
    run_i[g]  = 1'b1;
    srcb_i[g] = AW'(src);
    dstb_i[g] = AW'(dst);
    len_i[g]  = (AW+1)'(len);
    clr_i[g]  = clr;
    @(negedge clk);
    run_i[g] = 1'b0;
    clr_i[g] = 1'b0;
    check(g, "illegal_err", {63'b0, err_o[g]}, 64'd1);
    check(g, "illegal_idle", {63'b0, idle_o[g]}, 64'd1);
    repeat (4) @(negedge clk);
    check(g, "illegal_no_we", 64'(we_cnt[g] - we0), 64'd0);
    check(g, "illegal_no_ce", 64'(ce_cnt[g] - ce0), 64'd0);
    clr_i[g] = 1'b1;
    @(negedge clk);
    clr_i[g] = 1'b0;
    check(g, "clr_err", {63'b0, err_o[g]}, 64'd0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    fill   = 1'b1;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    fill   = 1'b0;
  endtask

  task automatic suite(input int g);
    int st, st2, we0, ce0, lat;
    lat = lat_of(g);

    do_reset();
    check(g, "rst_idle", {63'b0, idle_o[g]}, 64'd1);
    check(g, "rst_run", {63'b0, run_o[g]}, 64'd0);
    check(g, "rst_err", {63'b0, err_o[g]}, 64'd0);
    check(g, "rst_done", {63'b0, done_o[g]}, 64'd0);
    check(g, "rst_ce_we", {61'b0, src_ce_o[g], dst_ce_o[g], dst_we_o[g]}, 64'd0);
    check(g, "rst_addr_d", {25'b0, src_addr_o[g], dst_addr_o[g], dst_d_o[g][24:0]}, 64'd0);

    // COPY src 10 -> dst 50, len 20, plus a stray i_run while busy
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    launch(g, 1'b0, 10, 50, 20, 20, 1'b1, st);
    repeat (3) @(negedge clk);
    run_i[g] = 1'b1;
    len_i[g] = '0;
    @(negedge clk);
    run_i[g] = 1'b0;
    check(g, "busy_run_err", {63'b0, err_o[g]}, 64'd1);
    check(g, "busy_still_run", {63'b0, run_o[g]}, 64'd1);
    repeat (20 + lat) @(negedge clk);
    finish_chk(g, we0, ce0, 20, 20);
    check(g, "dst49_untouched", 64'(dst_mem[g][49]), 64'h A5A5A5A5);
    check(g, "dst70_untouched", 64'(dst_mem[g][70]), 64'h A5A5A5A5);
    check(g, "dst69", 64'(dst_mem[g][69]), 64'h1D1D1D1D);
    clr_i[g] = 1'b1;
    @(negedge clk);
    clr_i[g] = 1'b0;
    check(g, "clr_after_busy", {63'b0, err_o[g]}, 64'd0);

    // CLEAR dst 5, len 8
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    launch(g, 1'b1, 0, 5, 8, 8, 1'b1, st);
    repeat (8 + lat + 3) @(negedge clk);
    finish_chk(g, we0, ce0, 8, 0);
    check(g, "clr_dst5", 64'(dst_mem[g][5]), 64'd0);
    check(g, "clr_dst12", 64'(dst_mem[g][12]), 64'd0);
    check(g, "clr_dst13", 64'(dst_mem[g][13]), 64'hA5A5A5A5);

    // full COPY, len 100
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    launch(g, 1'b0, 0, 0, 100, 100, 1'b1, st);
    repeat (100 + lat + 3) @(negedge clk);
    finish_chk(g, we0, ce0, 100, 100);
    check(g, "dst37", 64'(dst_mem[g][37]), 64'h25252525);
`ifdef MEM_COPY_RELU_EN
    check(g, "dst99_relu", 64'(dst_mem[g][99]), 64'h007F0001);
`else
    check(g, "dst99_copy", 64'(dst_mem[g][99]), 64'hFF7F8001);
`endif

    // illegal starts; the last one clears and errs in the same cycle
    illegal(g, 0, 0, 0, 1'b0);
    illegal(g, 90, 0, 20, 1'b0);
    illegal(g, 0, 81, 20, 1'b1);

    // abort during cycle 10 of a len-50 copy
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    launch(g, 1'b0, 0, 0, 50, 10 - lat, 1'b0, st);
    while (cyc < st + 10) @(negedge clk);
    abort_i[g] = 1'b1;
    @(negedge clk);
    abort_i[g] = 1'b0;
    check(g, "abort_we", {63'b0, dst_we_o[g]}, 64'd0);
    check(g, "abort_idle", {63'b0, idle_o[g]}, 64'd1);
    repeat (10) @(negedge clk);
    finish_chk(g, we0, ce0, 10 - lat, 10);
    abort_i[g] = 1'b1;
    @(negedge clk);
    abort_i[g] = 1'b0;
    check(g, "abort_in_idle", {62'b0, idle_o[g], err_o[g]}, 64'd2);

    // areset during cycle 10 of a len-30 copy
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    launch(g, 1'b0, 0, 0, 30, 10 - 1 - lat, 1'b0, st);
    while (cyc < st + 10) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    check(g, "mid_rst_state", {61'b0, idle_o[g], run_o[g], dst_we_o[g]}, 64'd4);
    repeat (10) @(negedge clk);
    finish_chk(g, we0, ce0, 10 - 1 - lat, 10);

    // boundary ranges, second start on the done cycle of the first
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    launch(g, 1'b0, 80, 0, 20, 20, 1'b1, st);
    while (cyc < st + 20 + lat + 1) @(negedge clk);
    check(g, "b2b_idle_on_done", {62'b0, idle_o[g], done_o[g]}, 64'd3);
    launch(g, 1'b0, 0, 80, 20, 20, 1'b1, st2);
    repeat (20 + lat + 3) @(negedge clk);
    finish_chk(g, we0, ce0, 40, 40);
    check(g, "b2b_no_err", {63'b0, err_o[g]}, 64'd0);
    check(g, "b2b_dst99", 64'(dst_mem[g][99]), 64'h13131313);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) src_mem[i] = i * 32'h01010101;
    src_mem[95] = 32'h7F80FF01;
    src_mem[99] = 32'hFF7F8001;
    for (int g = 0; g < 2; g++) begin
      run_i[g] = 1'b0; mode_i[g] = 1'b0; abort_i[g] = 1'b0; clr_i[g] = 1'b0;
      srcb_i[g] = '0; dstb_i[g] = '0; len_i[g] = '0;
      wr_h[g] = 0; wr_tl[g] = 0; dn_h[g] = 0; dn_tl[g] = 0;
      we_cnt[g] = 0; ce_cnt[g] = 0;
    end
    @(negedge clk);
    suite(0);
    suite(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
